hwpf_issue_ctrl: RTL and testbench

//  Drains the prefetch queue and shares the single L1D->L2 miss request port between demand misses and prefetches.

---
 rtl/hwpf_pkg.sv | 23 ++
 rtl/hwpf_inflight_table.sv | 79 +++++++
 rtl/hwpf_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_hwpf_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpf_pkg.sv
// Shared types and default configuration for the prefetch issue controller.
package hwpf_pkg;

   localparam int unsigned DEF_ADDR_WIDTH   = 40;
   localparam int unsigned DEF_LINE_OFFSET  = 6;
   localparam int unsigned DEF_PF_MAX_OUTST = 4;
   localparam int unsigned DEF_STARVE_LIMIT = 16;

   localparam int unsigned DEF_LINE_WIDTH = DEF_ADDR_WIDTH - DEF_LINE_OFFSET;
   localparam int unsigned DEF_SLOT_WIDTH = $clog2(DEF_PF_MAX_OUTST);

   // Line address and in-flight slot index for the default configuration.
   typedef logic [DEF_LINE_WIDTH-1:0] line_addr_t;
   typedef logic [DEF_SLOT_WIDTH-1:0] pf_slot_t;

   // Output register occupancy: empty, holding a demand, holding a prefetch.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD_DMD = 2'd1,
      HOLD_PF  = 2'd2
   } issue_state_e;

endpackage

// File: rtl/hwpf_inflight_table.sv
// Table of in-flight prefetch lines: lowest-free allocation, two free ports,
// line lookup and a registered occupancy count.
module hwpf_inflight_table
   import hwpf_pkg::*;
#(
   parameter int unsigned NUM_SLOTS  = DEF_PF_MAX_OUTST,
   parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
   localparam int unsigned SW        = $clog2(NUM_SLOTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alloc,
   input  logic [LINE_WIDTH-1:0] alloc_line,
   input  logic                  rsp_free,
   input  logic [SW-1:0]         rsp_id,
   input  logic                  flush_free,
   input  logic [SW-1:0]         flush_id,
   input  logic [LINE_WIDTH-1:0] lookup_line,
   output logic                  slot_avail,
   output logic [SW-1:0]         free_slot,
   output logic                  hit,
   output logic [SW:0]           count
);

   logic [NUM_SLOTS-1:0]  valid;
   logic [NUM_SLOTS-1:0]  valid_next;
   logic [LINE_WIDTH-1:0] line [NUM_SLOTS];
   logic [SW:0]           count_next;

   // Lowest-index free slot search.
   always_comb begin
      slot_avail = 1'b0;
      free_slot  = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (!valid[i] && !slot_avail) begin
            slot_avail = 1'b1;
            free_slot  = SW'(i);
         end
      end
   end

   // Match the candidate line against every occupied slot.
   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (valid[i] && (line[i] == lookup_line)) hit = 1'b1;
      end
   end

   // Frees are applied before the allocation so an ignored free of the
   // slot being allocated cannot cancel the reservation.
   always_comb begin
      valid_next = valid;
      if (rsp_free)   valid_next[rsp_id]    = 1'b0;
      if (flush_free) valid_next[flush_id]  = 1'b0;
      if (alloc)      valid_next[free_slot] = 1'b1;
      count_next = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         count_next = count_next + (SW+1)'(valid_next[i]);
      end
   end

   // Slot state and occupancy count registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= '0;
         count <= '0;
      end else begin
         valid <= valid_next;
         count <= count_next;
      end
   end

   // Line storage; contents are only meaningful while the slot is valid.
   always_ff @(posedge clk) begin
      if (alloc) line[free_slot] <= alloc_line;
   end

endmodule

// File: rtl/hwpf_issue_ctrl.sv
// Shares the L2 miss request port between demand misses and prefetches:
// demand priority, outstanding-prefetch throttle, dedup and anti-starvation.
module hwpf_issue_ctrl
   import hwpf_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned LINE_OFFSET  = DEF_LINE_OFFSET,
   parameter int unsigned PF_MAX_OUTST = DEF_PF_MAX_OUTST,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
   localparam int unsigned SW          = $clog2(PF_MAX_OUTST)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  enable_i,
   input  logic                  pf_valid_i,
   input  logic [ADDR_WIDTH-1:0] pf_addr_i,
   output logic                  pf_read_o,
   input  logic                  dmd_valid_i,
   input  logic [ADDR_WIDTH-1:0] dmd_addr_i,
   output logic                  dmd_ready_o,
   output logic                  mem_req_valid_o,
   output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
   output logic                  mem_req_is_pf_o,
   output logic [SW-1:0]         mem_req_id_o,
   input  logic                  mem_req_ready_i,
   input  logic                  mem_rsp_valid_i,
   input  logic                  mem_rsp_is_pf_i,
   input  logic [SW-1:0]         mem_rsp_id_i,
   output logic [SW:0]           pf_inflight_o,
   output logic                  pf_drop_o
);

   localparam int unsigned LINE_WIDTH = ADDR_WIDTH - LINE_OFFSET;
   localparam int unsigned CNT_WIDTH  = $clog2(STARVE_LIMIT + 1);

   issue_state_e          state;
   logic [CNT_WIDTH-1:0]  starve_cnt;
   logic [LINE_WIDTH-1:0] pf_line;
   logic [LINE_WIDTH-1:0] dmd_line;
   logic [LINE_WIDTH-1:0] held_line;
   logic                  handshake;
   logic                  can_load;
   logic                  flush_drop;
   logic                  pf_cand;
   logic                  starved;
   logic                  pf_wins;
   logic                  pf_dup;
   logic                  take_dmd;
   logic                  pop;
   logic                  load_pf;
   logic                  slot_avail;
   logic [SW-1:0]         free_slot;
   logic                  tbl_hit;
   logic                  unused_offsets;

   assign pf_line        = pf_addr_i[ADDR_WIDTH-1:LINE_OFFSET];
   assign dmd_line       = dmd_addr_i[ADDR_WIDTH-1:LINE_OFFSET];
   assign held_line      = mem_req_addr_o[ADDR_WIDTH-1:LINE_OFFSET];
   assign unused_offsets = ^{pf_addr_i[LINE_OFFSET-1:0], dmd_addr_i[LINE_OFFSET-1:0]};

   // Load arbitration: demand first unless the prefetch has starved.
   // Combinational handshakes are gated by rst_ni so all outputs read 0
   // while reset is held.
   always_comb begin
      handshake  = mem_req_valid_o & mem_req_ready_i;
      can_load   = (state == IDLE) | handshake;
      flush_drop = flush_i & (state == HOLD_PF) & ~handshake;
      pf_cand    = enable_i & pf_valid_i & slot_avail & ~flush_i;
      starved    = (starve_cnt >= CNT_WIDTH'(STARVE_LIMIT));
      pf_wins    = pf_cand & (~dmd_valid_i | starved);
      pf_dup     = tbl_hit
                 | (mem_req_valid_o & (held_line == pf_line))
                 | (dmd_valid_i & (dmd_line == pf_line));
      take_dmd   = rst_ni & can_load & dmd_valid_i & ~pf_wins;
      pop        = rst_ni & can_load & pf_wins;
      load_pf    = pop & ~pf_dup;
      dmd_ready_o = take_dmd;
      pf_read_o   = pop;
      pf_drop_o   = pop & pf_dup;
   end

   hwpf_inflight_table #(
      .NUM_SLOTS  (PF_MAX_OUTST),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_table (
      .clk         (clk_i),
      .rst_n       (rst_ni),
      .alloc       (load_pf),
      .alloc_line  (pf_line),
      .rsp_free    (mem_rsp_valid_i & mem_rsp_is_pf_i),
      .rsp_id      (mem_rsp_id_i),
      .flush_free  (flush_drop),
      .flush_id    (mem_req_id_o),
      .lookup_line (pf_line),
      .slot_avail  (slot_avail),
      .free_slot   (free_slot),
      .hit         (tbl_hit),
      .count       (pf_inflight_o)
   );

   // Starvation counter: counts cycles a ready prefetch lost to demand.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         starve_cnt <= '0;
      end else if (pf_cand & take_dmd) begin
         starve_cnt <= starve_cnt + CNT_WIDTH'(1);
      end else begin
         starve_cnt <= '0;
      end
   end

   // Issue FSM with the output request register; a new request may be
   // loaded in the same cycle the held one handshakes.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state           <= IDLE;
         mem_req_valid_o <= 1'b0;
         mem_req_addr_o  <= '0;
         mem_req_is_pf_o <= 1'b0;
         mem_req_id_o    <= '0;
      end else if (take_dmd) begin
         state           <= HOLD_DMD;
         mem_req_valid_o <= 1'b1;
         mem_req_addr_o  <= {dmd_line, {LINE_OFFSET{1'b0}}};
         mem_req_is_pf_o <= 1'b0;
         mem_req_id_o    <= '0;
      end else if (load_pf) begin
         state           <= HOLD_PF;
         mem_req_valid_o <= 1'b1;
         mem_req_addr_o  <= {pf_line, {LINE_OFFSET{1'b0}}};
         mem_req_is_pf_o <= 1'b1;
         mem_req_id_o    <= free_slot;
      end else if (handshake | flush_drop) begin
         state           <= IDLE;
         mem_req_valid_o <= 1'b0;
         mem_req_addr_o  <= '0;
         mem_req_is_pf_o <= 1'b0;
         mem_req_id_o    <= '0;
      end
   end

endmodule

// File: tb/tb_hwpf_issue_ctrl.sv
// Self-checking bench for hwpf_issue_ctrl: directed scenarios plus random
// traffic, checked by a transaction-level reference model and a request
// scoreboard drained by an independent monitor.
module tb_hwpf_issue_ctrl;
   import hwpf_pkg::*;

   localparam int NS = 4;
   localparam int SL = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i, enable_i, pf_valid_i, dmd_valid_i;
   logic [39:0] pf_addr_i, dmd_addr_i;
   logic        pf_read_o, dmd_ready_o, mem_req_valid_o, mem_req_is_pf_o;
   logic [39:0] mem_req_addr_o;
   logic [1:0]  mem_req_id_o, mem_rsp_id_i;
   logic        mem_req_ready_i, mem_rsp_valid_i, mem_rsp_is_pf_i;
   logic [2:0]  pf_inflight_o;
   logic        pf_drop_o;

   always #5 clk_i = ~clk_i;

   hwpf_issue_ctrl #(
      .ADDR_WIDTH   (40),
      .LINE_OFFSET  (6),
      .PF_MAX_OUTST (NS),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .enable_i        (enable_i),
      .pf_valid_i      (pf_valid_i),
      .pf_addr_i       (pf_addr_i),
      .pf_read_o       (pf_read_o),
      .dmd_valid_i     (dmd_valid_i),
      .dmd_addr_i      (dmd_addr_i),
      .dmd_ready_o     (dmd_ready_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_is_pf_o (mem_req_is_pf_o),
      .mem_req_id_o    (mem_req_id_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_is_pf_i (mem_rsp_is_pf_i),
      .mem_rsp_id_i    (mem_rsp_id_i),
      .pf_inflight_o   (pf_inflight_o),
      .pf_drop_o       (pf_drop_o)
   );

   typedef struct {
      logic [39:0] addr;
      bit          is_pf;
      int          id;
   } req_t;

   // Reference model state
   bit         occ [NS];
   bit         issued [NS];
   line_addr_t occ_line [NS];
   bit         h_valid, h_is_pf;
   line_addr_t h_line;
   int         h_id;
   int         starve;
   req_t       exp_q [$];

   int checks = 0;
   int failures = 0;
   bit s_pop, s_dr, s_drop;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         occ[i] = 0;
         issued[i] = 0;
      end
      h_valid = 0;
      starve = 0;
      exp_q.delete();
   endtask

   // Monitor: every accepted request must match the oldest expected one.
   always @(negedge clk_i) begin
      req_t e;
      if (rst_ni && mem_req_valid_o && mem_req_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req actual=%0h required=none", mem_req_addr_o);
         end else begin
            e = exp_q.pop_front();
            check("req_addr", 64'(mem_req_addr_o), 64'(e.addr));
            check("req_is_pf", 64'(mem_req_is_pf_o), 64'(e.is_pf));
            check("req_id", 64'(mem_req_id_o), 64'(e.id));
         end
      end
   end

   // One clock: inputs already driven; compare, advance the model, move to next edge+1.
   task automatic step();
      line_addr_t pl, dl;
      int  nocc, lowfree;
      bit  hs, canload, pfc, pfwin, dup, e_dr, e_pop, e_drop;
      #1;
      if (!rst_ni) begin
         check("rst_dmd_ready", 64'(dmd_ready_o), 64'(0));
         check("rst_pf_read", 64'(pf_read_o), 64'(0));
         check("rst_pf_drop", 64'(pf_drop_o), 64'(0));
         s_pop = 0; s_dr = 0; s_drop = 0;
         model_reset();
      end else begin
         pl = pf_addr_i[39:6];
         dl = dmd_addr_i[39:6];
         nocc = 0;
         lowfree = -1;
         for (int i = 0; i < NS; i++) begin
            if (occ[i]) nocc++;
            else if (lowfree < 0) lowfree = i;
         end
         hs      = h_valid && mem_req_ready_i;
         canload = !h_valid || hs;
         pfc     = enable_i && pf_valid_i && (nocc < NS) && !flush_i;
         pfwin   = pfc && (!dmd_valid_i || starve >= SL);
         dup     = (h_valid && h_line == pl) || (dmd_valid_i && dl == pl);
         for (int i = 0; i < NS; i++) if (occ[i] && occ_line[i] == pl) dup = 1;
         e_dr   = canload && dmd_valid_i && !pfwin;
         e_pop  = canload && pfwin;
         e_drop = e_pop && dup;
         s_pop = pf_read_o; s_dr = dmd_ready_o; s_drop = pf_drop_o;

         check("dmd_ready", 64'(dmd_ready_o), 64'(e_dr));
         check("pf_read", 64'(pf_read_o), 64'(e_pop));
         check("pf_drop", 64'(pf_drop_o), 64'(e_drop));
         check("req_valid", 64'(mem_req_valid_o), 64'(h_valid));
         check("inflight", 64'(pf_inflight_o), 64'(nocc));

         if (hs && h_is_pf) issued[h_id] = 1;
         if (flush_i && h_valid && h_is_pf && !hs) begin
            occ[h_id] = 0;
            issued[h_id] = 0;
            exp_q.delete(exp_q.size() - 1);
            h_valid = 0;
         end
         if (mem_rsp_valid_i && mem_rsp_is_pf_i) begin
            occ[mem_rsp_id_i] = 0;
            issued[mem_rsp_id_i] = 0;
         end
         starve = (pfc && e_dr) ? starve + 1 : 0;
         if (e_dr) begin
            h_valid = 1; h_is_pf = 0; h_line = dl; h_id = 0;
            exp_q.push_back('{addr: {dl, 6'b0}, is_pf: 0, id: 0});
         end else if (e_pop && !dup) begin
            occ[lowfree] = 1; issued[lowfree] = 0; occ_line[lowfree] = pl;
            h_valid = 1; h_is_pf = 1; h_line = pl; h_id = lowfree;
            exp_q.push_back('{addr: {pl, 6'b0}, is_pf: 1, id: lowfree});
         end else if (hs) begin
            h_valid = 0;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      rst_ni = 1; flush_i = 0; enable_i = 1; pf_valid_i = 0; dmd_valid_i = 0;
      mem_req_ready_i = 1; mem_rsp_valid_i = 0; mem_rsp_is_pf_i = 0; mem_rsp_id_i = 0;
   endtask

   task automatic pf_step(logic [39:0] a);
      set_idle();
      pf_valid_i = 1; pf_addr_i = a;
      step();
   endtask

   task automatic rsp_step(int id);
      set_idle();
      mem_rsp_valid_i = 1; mem_rsp_is_pf_i = 1; mem_rsp_id_i = 2'(id);
      step();
   endtask

   initial begin
      int first_pop;
      bit pop_dr;
      // Reset with every input active
      rst_ni = 0; flush_i = 1; enable_i = 1; pf_valid_i = 1; dmd_valid_i = 1;
      pf_addr_i = 40'h2080; dmd_addr_i = 40'h1000; mem_req_ready_i = 1;
      mem_rsp_valid_i = 1; mem_rsp_is_pf_i = 1; mem_rsp_id_i = 2'd1;
      @(posedge clk_i); #1;
      step();
      check("rst_req_valid", 64'(mem_req_valid_o), 64'(0));
      check("rst_req_addr", 64'(mem_req_addr_o), 64'(0));
      check("rst_req_is_pf", 64'(mem_req_is_pf_o), 64'(0));
      check("rst_req_id", 64'(mem_req_id_o), 64'(0));
      check("rst_inflight", 64'(pf_inflight_o), 64'(0));
      pf_step(40'h2080);
      check("first_pop", 64'(s_pop), 64'(1));

      // Demand priority, prefetch follows back-to-back
      set_idle();
      dmd_valid_i = 1; dmd_addr_i = 40'h1000; pf_valid_i = 1; pf_addr_i = 40'h2040;
      step();
      pf_step(40'h2040);
      check("prio_pf_addr", 64'(mem_req_addr_o), 64'h2040);
      set_idle(); step();
      rsp_step(0); rsp_step(1);

      // Throttle at PF_MAX_OUTST, then reuse of a freed slot
      for (int k = 0; k < 5; k++) pf_step(40'h4000 + 40'(k * 64));
      check("throttle_full", 64'(pf_inflight_o), 64'(4));
      check("throttle_no_pop", 64'(s_pop), 64'(0));
      rsp_step(2);
      pf_step(40'h4400);
      check("reuse_pop", 64'(s_pop), 64'(1));
      set_idle(); step();
      for (int k = 0; k < 4; k++) rsp_step(k);

      // Dedup against an in-flight line
      pf_step(40'h3000);
      set_idle(); step();
      pf_step(40'h3010);
      check("dedup_drop", 64'(s_drop), 64'(1));
      check("dedup_count", 64'(pf_inflight_o), 64'(1));

      // Starvation under continuous demand
      first_pop = -1; pop_dr = 0;
      for (int k = 0; k < 20; k++) begin
         set_idle();
         dmd_valid_i = 1; dmd_addr_i = 40'h8000 + 40'(k * 64);
         pf_valid_i = (first_pop < 0); pf_addr_i = 40'h9000;
         step();
         if (s_pop && first_pop < 0) begin
            first_pop = k;
            pop_dr = s_dr;
         end
      end
      check("starve_cycle", 64'(first_pop), 64'(SL));
      check("starve_dmd_ready", 64'(pop_dr), 64'(0));

      // Flush of a held prefetch, then of a held demand
      set_idle(); step();
      set_idle(); mem_req_ready_i = 0; pf_valid_i = 1; pf_addr_i = 40'h7000; step();
      set_idle(); mem_req_ready_i = 0; flush_i = 1; step();
      check("flush_pf_valid", 64'(mem_req_valid_o), 64'(0));
      check("flush_pf_count", 64'(pf_inflight_o), 64'(2));
      set_idle(); mem_req_ready_i = 0; dmd_valid_i = 1; dmd_addr_i = 40'h7100; step();
      set_idle(); mem_req_ready_i = 0; flush_i = 1; step();
      check("flush_dmd_valid", 64'(mem_req_valid_o), 64'(1));
      set_idle(); step();
      for (int k = 0; k < 4; k++) rsp_step(k);

      // Random traffic over a small line pool so duplicates are frequent
      for (int n = 0; n < 3000; n++) begin
         set_idle();
         rst_ni          = ($urandom_range(0, 499) != 0);
         dmd_valid_i     = ($urandom_range(0, 2) == 0);
         dmd_addr_i      = 40'h10000 + 40'($urandom_range(0, 11) * 64) + 40'($urandom_range(0, 63));
         pf_valid_i      = ($urandom_range(0, 3) != 0);
         pf_addr_i       = 40'h10000 + 40'($urandom_range(0, 11) * 64) + 40'($urandom_range(0, 63));
         enable_i        = ($urandom_range(0, 7) != 0);
         flush_i         = ($urandom_range(0, 19) == 0);
         mem_req_ready_i = ($urandom_range(0, 3) != 0);
         mem_rsp_valid_i = ($urandom_range(0, 2) == 0);
         mem_rsp_is_pf_i = ($urandom_range(0, 7) != 0);
         mem_rsp_id_i    = 2'($urandom_range(0, 3));
         if (occ[mem_rsp_id_i] && !issued[mem_rsp_id_i]) mem_rsp_valid_i = 0;
         step();
      end

      // Drain and confirm nothing expected is left outstanding
      for (int k = 0; k < 4; k++) begin
         set_idle(); step();
      end
      check("drain_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
